// File: rtl/wide_add_seq.sv
// wide_add_seq: limb-serial wide adder. One 8-bit add slice is reused for
// every limb, LSB limb first, with the carry held in a register between
// limbs. Operands enter on a valid/ready channel. The result is presented on
// a second valid/ready channel and held until it is taken.
module wide_add_seq #(
  parameter  int WORDS = 4,
  localparam int W     = 8 * WORDS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_cout
);

  // Limb index needs at least one bit even when there is a single limb.
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  sum_reg;
  logic          cout_reg;
  logic          in_ready_reg;
  logic          out_valid_reg;

  logic [7:0] a_limbs [WORDS];
  logic [7:0] b_limbs [WORDS];
  logic [7:0] limb_a;
  logic [7:0] limb_b;
  logic [8:0] limb_res;

  // Split the captured operands into 8-bit limbs.
  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_limb
      assign a_limbs[gi] = a_reg[8*gi +: 8];
      assign b_limbs[gi] = b_reg[8*gi +: 8];
    end
  endgenerate

  // Select the current limb and run it through the shared 9-bit-exact slice.
  always_comb begin
    limb_a = 8'h00;
    limb_b = 8'h00;
    for (int k = 0; k < WORDS; k++) begin
      if (idx_reg == IW'(k)) begin
        limb_a = a_limbs[k];
        limb_b = b_limbs[k];
      end
    end
    limb_res = {1'b0, limb_a} + {1'b0, limb_b} + {8'h00, carry_reg};
  end

  // Control FSM plus datapath registers; all outputs come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      carry_reg     <= 1'b0;
      idx_reg       <= '0;
      sum_reg       <= '0;
      cout_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg        <= in_a;
            b_reg        <= in_b;
            carry_reg    <= in_cin;
            idx_reg      <= '0;
            in_ready_reg <= 1'b0;
            state_reg    <= RUN;
          end
        end
        RUN: begin
          for (int k = 0; k < WORDS; k++) begin
            if (idx_reg == IW'(k)) begin
              sum_reg[8*k +: 8] <= limb_res[7:0];
            end
          end
          carry_reg <= limb_res[8];
          if (idx_reg == LAST_IDX) begin
            // Last limb: its carry is the carry out of the whole word.
            cout_reg      <= limb_res[8];
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          // Result is held until taken; input reopens only the cycle after.
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;

endmodule

// File: tb/tb_wide_add_seq.sv
// Testbench for wide_add_seq: directed vector table, backpressure and
// mid-operation reset sequences, a single-limb instance, and randomized
// traffic checked against plain wide arithmetic with an in-order queue.
module tb_wide_add_seq;

  localparam int NRAND = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, in_cin;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_ready, out_cout;
  logic [31:0] out_sum;

  logic        in_valid1, in_ready1, in_cin1;
  logic [7:0]  in_a1, in_b1;
  logic        out_valid1, out_ready1, out_cout1;
  logic [7:0]  out_sum1;

  int checks = 0;
  int failures = 0;

  wide_add_seq #(.WORDS(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  wide_add_seq #(.WORDS(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_cin(in_cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_cout(out_cout1)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and wait (bounded) for the accept edge.
  task automatic accept_op(input logic [31:0] a, input logic [31:0] b, input logic cin);
    int guard;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    check("accept_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  // Count edges after the accept edge until out_valid is visible.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        output logic [31:0] s, output logic c, output int lat);
    accept_op(a, b, cin);
    wait_valid(lat);
    s = out_sum;
    c = out_cout;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s;
    logic        c;
    int          lat;
    logic [32:0] exp_q [$];
    logic [32:0] e;
    int          sent, recv, gap, cyc;
    bit          presenting, acc_now;
    bit          saw_valid;

    vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    vecs[1] = '{32'h00000000, 32'h00000000, 1'b1, 32'h00000001, 1'b0};
    vecs[2] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    vecs[5] = '{32'h00FF00FF, 32'h00010001, 1'b0, 32'h01000100, 1'b0};
    vecs[6] = '{32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0};

    rst = 1'b1;
    in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; out_ready = 0;
    in_valid1 = 0; in_a1 = 0; in_b1 = 0; in_cin1 = 0; out_ready1 = 0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_cout", out_cout, 0);
    check("rst1_in_ready", in_ready1, 1);
    check("rst1_out_valid", out_valid1, 0);

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
      $display("vec %0d: a=%08h b=%08h cin=%0b -> sum=%08h cout=%0b lat=%0d",
               i, vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
      check("vec_sum", s, vecs[i].sum);
      check("vec_cout", c, vecs[i].cout);
      check("vec_latency", lat, 4);
      check("vec_post_valid", out_valid, 0);
      check("vec_post_ready", in_ready, 1);
    end

    // Backpressure: result held for 10 cycles while junk inputs are offered
    accept_op(32'h11111111, 32'h22222222, 1'b1);
    wait_valid(lat);
    check("bp_latency", lat, 4);
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b0;
      in_valid = (i % 2 == 0);
      in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
      tick();
      check("bp_valid", out_valid, 1);
      check("bp_sum", out_sum, 32'h33333334);
      check("bp_cout", out_cout, 0);
      check("bp_in_ready", in_ready, 0);
    end
    $display("bp: held sum=%08h cout=%0b for 10 cycles", out_sum, out_cout);
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_hs_valid", out_valid, 0);
    check("bp_hs_in_ready", in_ready, 1);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_idle_valid", out_valid, 0);
      check("bp_idle_ready", in_ready, 1);
    end

    // Reset during RUN, with a live carry and partial sum in flight
    accept_op(32'h000080FF, 32'h00008001, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready", in_ready, 1);
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_sum", out_sum, 0);
    check("mrst_out_cout", out_cout, 0);
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) saw_valid = 1'b1;
    end
    check("mrst_no_pulse", saw_valid, 0);
    run_op(32'h000000FF, 32'h00000001, 1'b0, s, c, lat);
    $display("mrst: a=000000ff b=00000001 -> sum=%08h cout=%0b lat=%0d", s, c, lat);
    check("mrst_sum", s, 32'h00000100);
    check("mrst_cout", c, 0);
    check("mrst_latency", lat, 4);

    // Single-limb instance
    in_a1 = 8'hFF; in_b1 = 8'hFF; in_cin1 = 1'b1; in_valid1 = 1'b1;
    check("w1_ready", in_ready1, 1);
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin
      tick();
      lat++;
    end
    $display("w1: a=ff b=ff cin=1 -> sum=%02h cout=%0b lat=%0d", out_sum1, out_cout1, lat);
    check("w1_latency", lat, 1);
    check("w1_sum", out_sum1, 8'hFF);
    check("w1_cout", out_cout1, 1);
    out_ready1 = 1'b1;
    tick();
    out_ready1 = 1'b0;
    check("w1_post_valid", out_valid1, 0);
    check("w1_post_ready", in_ready1, 1);

    // Randomized traffic against an in-order queue of exact wide sums
    sent = 0; recv = 0; gap = 0; cyc = 0; presenting = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    while (recv < NRAND && cyc < 60000) begin
      if (!presenting && sent < NRAND) begin
        if (gap > 0) begin
          gap--;
        end else begin
          in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
          in_valid = 1'b1;
          presenting = 1'b1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      acc_now = in_valid && in_ready;
      if (acc_now) begin
        exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + 33'(in_cin));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rand_unexpected: got sum=0x%08h cout=%0b with no operation pending",
                   out_sum, out_cout);
        end else begin
          e = exp_q.pop_front();
          checks--;
          check("rand_result", {31'b0, out_cout, out_sum}, {31'b0, e});
          $display("rand %0d: sum=%08h cout=%0b", recv, out_sum, out_cout);
          recv++;
        end
      end
      tick();
      cyc++;
      if (acc_now) begin
        in_valid = 1'b0;
        presenting = 1'b0;
        gap = $urandom_range(0, 2);
      end
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    check("rand_count", recv, NRAND);
    check("rand_leftover", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
